constant_issue_arbiter: RTL

Shares the constant-register scoreboard between NUM_REQ dispatch requesters, such as per-block fetch/decode slots, in the CGRA dispatcher.
- Keeps the pending-constant bitmap and an in-flight counter internally.
- Picks one hazard-free requester per cycle by round robin and reserves its write constants.
- Presents the granted request on a one-entry registered issue port with a valid/ready handshake.
- Releases constants on write-back.

---
 rtl/constant_issue_if.sv | 46 ++++
 rtl/constant_issue_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/constant_issue_if.sv
// Bundles the requester, issue, write-back and status signals of the
// constant-register issue arbiter. master = environment, slave = arbiter.
interface constant_issue_if #(
    parameter int NUM_REQ           = 4,
    parameter int NUM_CONSTANT_REGS = 32,
    parameter int MAX_INFLIGHT      = 8
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    // requester side
    logic [NUM_REQ-1:0]                        req_valid;
    logic [NUM_REQ-1:0][NUM_CONSTANT_REGS-1:0] req_rd_map;
    logic [NUM_REQ-1:0][NUM_CONSTANT_REGS-1:0] req_wr_map;
    logic [NUM_REQ-1:0]                        req_ready;

    // issue port
    logic                         issue_valid;
    logic                         issue_ready;
    logic [ID_W-1:0]              issue_id;
    logic [NUM_CONSTANT_REGS-1:0] issue_wr_map;

    // write-back
    logic                         wb_valid;
    logic [NUM_CONSTANT_REGS-1:0] wb_const_bitmap;

    // status
    logic [NUM_CONSTANT_REGS-1:0] pending_map;
    logic [CNT_W-1:0]             inflight;
    logic                         wb_err;
    logic [31:0]                  stall_cycles;

    modport master (
        output req_valid, req_rd_map, req_wr_map, issue_ready,
               wb_valid, wb_const_bitmap,
        input  req_ready, issue_valid, issue_id, issue_wr_map,
               pending_map, inflight, wb_err, stall_cycles
    );

    modport slave (
        input  req_valid, req_rd_map, req_wr_map, issue_ready,
               wb_valid, wb_const_bitmap,
        output req_ready, issue_valid, issue_id, issue_wr_map,
               pending_map, inflight, wb_err, stall_cycles
    );
endinterface

// File: rtl/constant_issue_arbiter.sv
// Constant-register scoreboard arbiter for the CGRA dispatcher.
// Round-robin picks one hazard-free requester per cycle, reserves its write
// constants at grant time and presents it on a one-entry issue register.
// Write-backs release constants and are visible to hazard checks in the
// same cycle.
// Optional: define CONST_ARB_STATS_EN to build the stall_cycles counter
// (cycles with a pending request but no grant); otherwise it reads 0.

// Per-requester hazard check: RAW and WAW against the effective pending map.
module const_hazard_chk #(
    parameter int NUM_CONSTANT_REGS = 32
) (
    input  logic                         valid,
    input  logic [NUM_CONSTANT_REGS-1:0] rd_map,
    input  logic [NUM_CONSTANT_REGS-1:0] wr_map,
    input  logic [NUM_CONSTANT_REGS-1:0] eff_pending,
    output logic                         elig
);
    assign elig = valid && (((rd_map | wr_map) & eff_pending) == '0);
endmodule

module constant_issue_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int NUM_CONSTANT_REGS = 32,
    parameter int MAX_INFLIGHT      = 8
) (
    input logic           clk,
    input logic           rst_n,
    constant_issue_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic [NUM_CONSTANT_REGS-1:0] pending_q;
    logic [NUM_CONSTANT_REGS-1:0] pending_d;
    logic [NUM_CONSTANT_REGS-1:0] wbm;
    logic [NUM_CONSTANT_REGS-1:0] eff_pending;
    logic [NUM_CONSTANT_REGS-1:0] win_wr_map;
    logic [NUM_REQ-1:0]           elig;
    logic [NUM_REQ-1:0]           grant_oh;
    logic [ID_W-1:0]              rr_ptr;
    logic [ID_W-1:0]              winner;
    logic                         found;
    logic                         slot_free;
    logic                         cap_ok;
    logic                         grant;

    logic                         issue_valid_q;
    logic [ID_W-1:0]              issue_id_q;
    logic [NUM_CONSTANT_REGS-1:0] issue_wr_q;
    logic [CNT_W-1:0]             cnt_q;
    logic                         err_q;

    // Write-back releases are applied before the hazard check.
    assign wbm         = bus.wb_valid ? bus.wb_const_bitmap : '0;
    assign eff_pending = pending_q & ~wbm;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_chk
            const_hazard_chk #(
                .NUM_CONSTANT_REGS(NUM_CONSTANT_REGS)
            ) u_chk (
                .valid       (bus.req_valid[g]),
                .rd_map      (bus.req_rd_map[g]),
                .wr_map      (bus.req_wr_map[g]),
                .eff_pending (eff_pending),
                .elig        (elig[g])
            );
        end
    endgenerate

    // Round-robin scan starting at rr_ptr; first eligible index wins.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    // A grant needs a free issue slot and in-flight headroom; a same-cycle
    // write-back frees one in-flight entry, so it also counts as headroom.
    assign slot_free  = !issue_valid_q || bus.issue_ready;
    assign cap_ok     = (cnt_q < CNT_W'(MAX_INFLIGHT)) || bus.wb_valid;
    assign grant      = slot_free && found && cap_ok;
    assign grant_oh   = grant ? (NUM_REQ'(1) << winner) : '0;
    assign win_wr_map = bus.req_wr_map[winner];

    // Reservation is OR-ed after the release so it wins on a shared bit.
    assign pending_d = eff_pending | (grant ? win_wr_map : '0);

    // Issue register: load on grant, drain on downstream accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid_q <= 1'b0;
            issue_id_q    <= '0;
            issue_wr_q    <= '0;
        end else if (grant) begin
            issue_valid_q <= 1'b1;
            issue_id_q    <= winner;
            issue_wr_q    <= win_wr_map;
        end else if (bus.issue_ready) begin
            issue_valid_q <= 1'b0;
        end
    end

    // Pending bitmap and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            rr_ptr    <= '0;
        end else begin
            pending_q <= pending_d;
            if (grant)
                rr_ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
        end
    end

    // In-flight counter and sticky underflow flag. A write-back seen at zero
    // is treated as stray: it never decrements, so a same-cycle grant at zero
    // still counts as one in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            case ({grant, bus.wb_valid})
                2'b10: cnt_q <= cnt_q + 1'b1;
                2'b01: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                2'b11: if (cnt_q == '0) cnt_q <= CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (bus.wb_valid && cnt_q == '0)
                err_q <= 1'b1;
        end
    end

`ifdef CONST_ARB_STATS_EN
    logic [31:0] stall_q;

    // Saturating count of cycles with a waiting request but no grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else if ((|bus.req_valid) && !grant && (stall_q != '1))
            stall_q <= stall_q + 1'b1;
    end

    assign bus.stall_cycles = stall_q;
`else
    assign bus.stall_cycles = '0;
`endif

    assign bus.req_ready    = grant_oh;
    assign bus.issue_valid  = issue_valid_q;
    assign bus.issue_id     = issue_id_q;
    assign bus.issue_wr_map = issue_wr_q;
    assign bus.pending_map  = pending_q;
    assign bus.inflight     = cnt_q;
    assign bus.wb_err       = err_q;
endmodule
